evo_lut_bank: RTL and testbench

- Parametrised, reprogrammable successor to the fixed four-input/four-output boolean candidate.
- Holds an N_IN-input, N_OUT-output truth table in registers and serves registered lookups.
- The table is loaded row by row through a handshake.
- Includes a scoring sweep that counts matching output bits against a streamed target table. This gives the evolution loop a hardware fitness value per candidate.

---
 rtl/evo_pkg.sv | 19 +
 rtl/evo_lut_bank_if.sv | 39 +++
 rtl/evo_lut_bank_popcount.sv | 18 +
 rtl/evo_lut_bank.sv | 141 ++++++++++++++
 tb/tb_evo_lut_bank.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/evo_pkg.sv
// Shared types and helpers for the evolvable LUT bank and later fitness blocks.
// No logic here: FSM state encoding, table-init modes and a score-width helper.
package evo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SCORE = 2'd2
  } lut_state_t;

  localparam int INIT_MODE_ZEROS = 0;
  localparam int INIT_MODE_ONES  = 1;

  // Wide enough to hold every possible match count, 0..rows*bits inclusive.
  function automatic int score_width(input int rows, input int bits);
    return $clog2(rows * bits + 1);
  endfunction

endpackage

// File: rtl/evo_lut_bank_if.sv
// Config, target-stream, score and lookup signals of evo_lut_bank.
// cfg/tgt beats stall on valid low; lookups and score are single-cycle pulses.
interface evo_lut_bank_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4
) ();
  import evo_pkg::*;

  localparam int SCORE_W = score_width(2 ** N_IN, N_OUT);

  logic               cfg_start;
  logic               cfg_valid;
  logic [N_OUT-1:0]   cfg_data;
  logic               cfg_ready;
  logic               cfg_done;
  logic               score_start;
  logic               tgt_valid;
  logic [N_OUT-1:0]   tgt_data;
  logic [SCORE_W-1:0] score;
  logic               score_valid;
  logic               in_valid;
  logic [N_IN-1:0]    in_data;
  logic               out_valid;
  logic [N_OUT-1:0]   out_data;
  logic               busy;

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, score_start, tgt_valid, tgt_data,
           in_valid, in_data,
    output cfg_ready, cfg_done, score, score_valid, out_valid, out_data, busy
  );

  modport master (
    output cfg_start, cfg_valid, cfg_data, score_start, tgt_valid, tgt_data,
           in_valid, in_data,
    input  cfg_ready, cfg_done, score, score_valid, out_valid, out_data, busy
  );

endinterface

// File: rtl/evo_lut_bank_popcount.sv
// Combinational population count of a W-bit vector, zero-extended to CNT_W.
// Zero latency, no flow control.
module evo_popcount #(
  parameter int W     = 4,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     i_bits,
  output logic [CNT_W-1:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < W; i++) begin
      o_count = o_count + CNT_W'(i_bits[i]);
    end
  end

endmodule

// File: rtl/evo_lut_bank.sv
// Reprogrammable N_IN->N_OUT truth table: 1-cycle registered lookup in IDLE, row-wise load,
// and a scoring sweep against a streamed target; load/score beats stall while valid is low.
module evo_lut_bank
  import evo_pkg::*;
#(
  parameter int N_IN      = 4,
  parameter int N_OUT     = 4,
  parameter int INIT_ONES = 1
) (
  input  logic           clk,
  input  logic           reset,
  evo_lut_bank_if.slave  bus
);

  localparam int ROWS    = 2 ** N_IN;
  localparam int SCORE_W = score_width(ROWS, N_OUT);
  localparam logic [N_OUT-1:0] ROW_INIT =
    (INIT_ONES == INIT_MODE_ONES) ? {N_OUT{1'b1}} : {N_OUT{1'b0}};
  localparam logic [N_IN-1:0] LAST_ROW = N_IN'(ROWS - 1);

  lut_state_t         r_state;
  logic [N_IN-1:0]    r_ptr;
  logic [SCORE_W-1:0] r_acc;
  logic [SCORE_W-1:0] r_score;
  logic               r_score_vld;
  logic               r_cfg_done;
  logic               r_busy;
  logic               r_out_vld;
  logic [N_OUT-1:0]   r_out_dat;
  logic [N_OUT-1:0]   r_table [ROWS];

  lut_state_t         w_state_nxt;
  logic [N_IN-1:0]    w_ptr_nxt;
  logic [SCORE_W-1:0] w_acc_nxt;
  logic               w_wr_en;
  logic               w_load_last;
  logic               w_score_last;
  logic [N_OUT-1:0]   w_match;
  logic [SCORE_W-1:0] w_row_hits;

  assign w_match = ~(r_table[r_ptr] ^ bus.tgt_data);

  evo_popcount #(
    .W     (N_OUT),
    .CNT_W (SCORE_W)
  ) u_popcount (
    .i_bits  (w_match),
    .o_count (w_row_hits)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_acc_nxt    = r_acc;
    w_wr_en      = 1'b0;
    w_load_last  = 1'b0;
    w_score_last = 1'b0;
    case (r_state)
      IDLE: begin
        // A simultaneous load request wins over a scoring request.
        if (bus.cfg_start) begin
          w_state_nxt = LOAD;
          w_ptr_nxt   = '0;
        end else if (bus.score_start) begin
          w_state_nxt = SCORE;
          w_ptr_nxt   = '0;
          w_acc_nxt   = '0;
        end
      end
      LOAD: begin
        if (bus.cfg_valid) begin
          w_wr_en   = 1'b1;
          w_ptr_nxt = r_ptr + 1'b1;
          if (r_ptr == LAST_ROW) begin
            w_state_nxt = IDLE;
            w_load_last = 1'b1;
          end
        end
      end
      SCORE: begin
        if (bus.tgt_valid) begin
          w_acc_nxt = r_acc + w_row_hits;
          w_ptr_nxt = r_ptr + 1'b1;
          if (r_ptr == LAST_ROW) begin
            w_state_nxt  = IDLE;
            w_score_last = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_acc       <= '0;
      r_score     <= '0;
      r_score_vld <= 1'b0;
      r_cfg_done  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_vld   <= 1'b0;
      r_out_dat   <= '0;
      for (int i = 0; i < ROWS; i++) begin
        r_table[i] <= ROW_INIT;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_acc       <= w_acc_nxt;
      r_busy      <= (w_state_nxt != IDLE);
      r_cfg_done  <= w_load_last;
      r_score_vld <= w_score_last;
      if (w_score_last) begin
        r_score <= w_acc_nxt;
      end
      if (w_wr_en) begin
        r_table[r_ptr] <= bus.cfg_data;
      end
      // Reads the current table, so a lookup alongside a start pulse sees pre-load contents.
      if (r_state == IDLE && bus.in_valid) begin
        r_out_vld <= 1'b1;
        r_out_dat <= r_table[bus.in_data];
      end else begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign bus.cfg_ready   = (r_state == LOAD);
  assign bus.cfg_done    = r_cfg_done;
  assign bus.score       = r_score;
  assign bus.score_valid = r_score_vld;
  assign bus.out_valid   = r_out_vld;
  assign bus.out_data    = r_out_dat;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_evo_lut_bank.sv
// Directed bench for evo_lut_bank at default parameters and at N_IN=2/N_OUT=3/INIT_ONES=0.
module tb_evo_lut_bank;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  evo_lut_bank_if #(.N_IN(4), .N_OUT(4)) bus_a ();
  evo_lut_bank_if #(.N_IN(2), .N_OUT(3)) bus_b ();

  evo_lut_bank #(.N_IN(4), .N_OUT(4), .INIT_ONES(1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  evo_lut_bank #(.N_IN(2), .N_OUT(3), .INIT_ONES(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup_a(input string tag, input logic [3:0] addr, input logic [3:0] exp);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = addr;
    tick();
    bus_a.in_valid = 1'b0;
    check({tag, "_vld"}, bus_a.out_valid, 1);
    check({tag, "_dat"}, bus_a.out_data, exp);
  endtask

  // Sends 16 rows r^mask; optional 3-cycle stall after row gap_row. Caller has entered LOAD.
  task automatic load_a(input logic [3:0] mask, input int gap_row);
    for (int r = 0; r < 16; r++) begin
      bus_a.cfg_valid = 1'b1;
      bus_a.cfg_data  = 4'(r) ^ mask;
      tick();
      bus_a.cfg_valid = 1'b0;
      check("load_done", bus_a.cfg_done, (r == 15) ? 1 : 0);
      check("load_outvld", bus_a.out_valid, 0);
      check("load_noscore", bus_a.score_valid, 0);
      if (r == gap_row) begin
        for (int g = 0; g < 3; g++) begin
          tick();
          check("gap_ready", bus_a.cfg_ready, 1);
          check("gap_done", bus_a.cfg_done, 0);
        end
      end
    end
    check("load_end_ready", bus_a.cfg_ready, 0);
    check("load_end_busy", bus_a.busy, 0);
  endtask

  task automatic score_a(input logic [3:0] row_mask, input logic [31:0] exp);
    bus_a.score_start = 1'b1;
    tick();
    bus_a.score_start = 1'b0;
    check("score_busy", bus_a.busy, 1);
    for (int r = 0; r < 16; r++) begin
      bus_a.tgt_valid = 1'b1;
      bus_a.tgt_data  = 4'(r) & row_mask;
      tick();
      bus_a.tgt_valid = 1'b0;
      check("score_vld", bus_a.score_valid, (r == 15) ? 1 : 0);
    end
    check("score_val", bus_a.score, exp);
    tick();
    check("score_vld_pulse", bus_a.score_valid, 0);
    check("score_hold", bus_a.score, exp);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    {bus_a.cfg_start, bus_a.cfg_valid, bus_a.score_start, bus_a.tgt_valid, bus_a.in_valid} = '0;
    bus_a.cfg_data = '0; bus_a.tgt_data = '0; bus_a.in_data = '0;
    {bus_b.cfg_start, bus_b.cfg_valid, bus_b.score_start, bus_b.tgt_valid, bus_b.in_valid} = '0;
    bus_b.cfg_data = '0; bus_b.tgt_data = '0; bus_b.in_data = '0;
    tick();
    tick();
    check("rst_busy", bus_a.busy, 0);
    check("rst_score", bus_a.score, 0);
    check("rst_outvld", bus_a.out_valid, 0);
    check("rst_outdat", bus_a.out_data, 0);
    check("rst_ready", bus_a.cfg_ready, 0);
    check("rst_done", bus_a.cfg_done, 0);
    check("rst_svld", bus_a.score_valid, 0);
    check("rst_b_outdat", bus_b.out_data, 0);
    reset = 1'b0;
    tick();

    // Default table is all-ones; out_data holds when in_valid drops.
    lookup_a("lk_init", 4'hA, 4'hF);
    tick();
    check("lk_idle_vld", bus_a.out_valid, 0);
    check("lk_hold_dat", bus_a.out_data, 4'hF);

    // Identity load with a stall after row 5 and lookups requested throughout.
    bus_a.cfg_start = 1'b1;
    tick();
    bus_a.cfg_start = 1'b0;
    check("load_ready", bus_a.cfg_ready, 1);
    check("load_busy", bus_a.busy, 1);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 4'h2;
    load_a(4'h0, 5);
    bus_a.in_valid = 1'b0;
    tick();
    check("done_single", bus_a.cfg_done, 0);
    lookup_a("lk_ident", 4'h9, 4'h9);

    score_a(4'hF, 64);
    score_a(4'h0, 32);

    // Both starts together: load wins; a later score_start inside LOAD is ignored.
    bus_a.cfg_start   = 1'b1;
    bus_a.score_start = 1'b1;
    bus_a.in_valid    = 1'b1;
    bus_a.in_data     = 4'h7;
    tick();
    bus_a.cfg_start   = 1'b0;
    bus_a.in_valid    = 1'b0;
    check("both_ready", bus_a.cfg_ready, 1);
    check("both_prevld", bus_a.out_valid, 1);
    check("both_predat", bus_a.out_data, 4'h7);
    tick();
    bus_a.score_start = 1'b0;
    check("both_still_load", bus_a.cfg_ready, 1);
    load_a(4'hF, -1);
    check("both_score_hold", bus_a.score, 32);
    lookup_a("lk_compl", 4'h9, 4'h6);

    // Reset in the middle of a load.
    bus_a.cfg_start = 1'b1;
    tick();
    bus_a.cfg_start = 1'b0;
    for (int r = 0; r < 7; r++) begin
      bus_a.cfg_valid = 1'b1;
      bus_a.cfg_data  = 4'h0;
      tick();
    end
    bus_a.cfg_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", bus_a.busy, 0);
    check("mid_rst_ready", bus_a.cfg_ready, 0);
    check("mid_rst_score", bus_a.score, 0);
    check("mid_rst_done", bus_a.cfg_done, 0);
    lookup_a("lk_rst", 4'h3, 4'hF);
    check("mid_rst_nodone", bus_a.cfg_done, 0);

    // Small configuration: zero table, 4 rows x 3 bits.
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = 2'd1;
    tick();
    bus_b.in_valid = 1'b0;
    check("b_lk_vld", bus_b.out_valid, 1);
    check("b_lk_dat", bus_b.out_data, 0);
    for (int pass = 0; pass < 2; pass++) begin
      bus_b.score_start = 1'b1;
      tick();
      bus_b.score_start = 1'b0;
      for (int r = 0; r < 4; r++) begin
        bus_b.tgt_valid = 1'b1;
        bus_b.tgt_data  = (pass == 0) ? 3'b000 : 3'b101;
        tick();
        bus_b.tgt_valid = 1'b0;
        check("b_svld", bus_b.score_valid, (r == 3) ? 1 : 0);
      end
      check("b_score", bus_b.score, (pass == 0) ? 12 : 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
